// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register and operand-issue stage.
// Decodes ALUOp/funct into the 3-bit ALU Signal, registers the ID fields,
// detects load-use hazards and resolves RAW hazards by forwarding.
// Optional feature macro: ALU_ISSUE_FWD_EN enables the EX/MEM and MEM/WB
// forwarding muxes; without it the operands come straight from the register.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  id_aluop,
  input  logic [5:0]  id_funct,
  input  logic        id_alusrc,
  input  logic        id_memread,
  input  logic        id_regwrite,
  input  logic        stall,
  input  logic        flush,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [2:0]  Signal,
  output logic [31:0] ex_store_data,
  output logic        ex_valid,
  output logic        ex_memread,
  output logic        ex_regwrite,
  output logic [4:0]  ex_rd,
  output logic        ex_illegal,
  output logic        id_stall
);

  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SUB = 3'b110;
  localparam logic [2:0] SIG_SLT = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic        aluSrc;
    logic        memRead;
    logic        regWrite;
    logic [2:0]  signal;
    logic        illegal;
  } exReg_t;

  exReg_t      ex_q;
  exReg_t      ex_d;
  logic [2:0]  decSignal;
  logic        decIllegal;
  logic [31:0] fwdRs;
  logic [31:0] fwdRt;

  // Translate ALUOp/funct into the ALU operation code while still in ID
  always_comb begin
    decSignal  = SIG_ADD;
    decIllegal = 1'b0;
    case (id_aluop)
      2'b00: decSignal = SIG_ADD;
      2'b01: decSignal = SIG_SUB;
      2'b11: decSignal = SIG_OR;
      default: begin
        case (id_funct)
          6'b100000: decSignal = SIG_ADD;
          6'b100010: decSignal = SIG_SUB;
          6'b100100: decSignal = SIG_AND;
          6'b100101: decSignal = SIG_OR;
          6'b101010: decSignal = SIG_SLT;
          default: begin
            decSignal  = SIG_ADD;
            decIllegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // A load in EX whose destination is read by the ID instruction needs one bubble
  assign id_stall = ex_q.valid & ex_q.memRead & (ex_q.rd != 5'd0) & id_valid &
                    ((id_rs == ex_q.rd) | (id_rt == ex_q.rd));

  // Next EX contents: flush beats stall, stall beats the load-use bubble
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (id_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rs       = id_rs;
      ex_d.rt       = id_rt;
      ex_d.rd       = id_rd;
      ex_d.rsData   = id_rs_data;
      ex_d.rtData   = id_rt_data;
      ex_d.imm      = id_imm;
      ex_d.aluSrc   = id_alusrc;
      ex_d.memRead  = id_memread;
      ex_d.regWrite = id_regwrite;
      ex_d.signal   = decSignal;
      ex_d.illegal  = decIllegal & id_valid;
    end
  end

  // ID/EX register, cleared asynchronously so reset always leaves a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ALU_ISSUE_FWD_EN
  // Pick the newest producer of each source operand; r0 is hardwired zero
  always_comb begin
    fwdRs = ex_q.rsData;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rs)) begin
      fwdRs = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rs)) begin
      fwdRs = memwb_result;
    end
    fwdRt = ex_q.rtData;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == ex_q.rt)) begin
      fwdRt = exmem_result;
    end else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == ex_q.rt)) begin
      fwdRt = memwb_result;
    end
  end
`else
  logic unusedFwd;

  // Without forwarding the operands are exactly the values read in ID
  assign fwdRs     = ex_q.rsData;
  assign fwdRt     = ex_q.rtData;
  assign unusedFwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                       memwb_regwrite, memwb_rd, memwb_result};
`endif

  // Drive the ALU operands and the registered control bits
  assign dataA         = fwdRs;
  assign dataB         = ex_q.aluSrc ? ex_q.imm : fwdRt;
  assign ex_store_data = fwdRt;
  assign Signal        = ex_q.signal;
  assign ex_valid      = ex_q.valid;
  assign ex_memread    = ex_q.memRead;
  assign ex_regwrite   = ex_q.regWrite;
  assign ex_rd         = ex_q.rd;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table-driven decode/operand vectors
// plus hand-written sequences for forwarding, load-use, stall/flush and reset.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc;
  logic        id_memread;
  logic        id_regwrite;
  logic        stall;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [2:0]  Signal;
  logic [31:0] ex_store_data;
  logic        ex_valid;
  logic        ex_memread;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic        ex_illegal;
  logic        id_stall;

  int checks;
  int errors;

  typedef struct {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic        alusrc;
    logic [2:0]  expSig;
    logic        expIll;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  vec_t vecs[10];

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_funct(id_funct), .id_alusrc(id_alusrc),
    .id_memread(id_memread), .id_regwrite(id_regwrite),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .dataA(dataA), .dataB(dataB), .Signal(Signal), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal), .id_stall(id_stall)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [31:0] rsData, input logic [31:0] rtData,
                                 input logic [31:0] imm, input logic [1:0] aluop,
                                 input logic [5:0] funct, input logic alusrc,
                                 input logic [2:0] expSig, input logic expIll,
                                 input logic [31:0] expA, input logic [31:0] expB);
    vec_t v;
    v.valid = valid; v.rs = rs; v.rt = rt; v.rsData = rsData; v.rtData = rtData;
    v.imm = imm; v.aluop = aluop; v.funct = funct; v.alusrc = alusrc;
    v.expSig = expSig; v.expIll = expIll; v.expA = expA; v.expB = expB;
    return v;
  endfunction

  task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rsData,
                               input logic [31:0] rtData, input logic [31:0] imm,
                               input logic [1:0] aluop, input logic [5:0] funct,
                               input logic alusrc, input logic memread, input logic regwrite);
    id_valid = valid; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsData; id_rt_data = rtData; id_imm = imm;
    id_aluop = aluop; id_funct = funct; id_alusrc = alusrc;
    id_memread = memread; id_regwrite = regwrite;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearFwd();
    exmem_regwrite = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_regwrite = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = mkVec(1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'b10, 6'b100000, 0, 3'b010, 0, 32'd5, 32'd7);
    vecs[1] = mkVec(1, 5'd1, 5'd2, 32'd20, 32'd3, 32'd0, 2'b10, 6'b100010, 0, 3'b110, 0, 32'd20, 32'd3);
    vecs[2] = mkVec(1, 5'd3, 5'd4, 32'hF0F0, 32'h0FF0, 32'd0, 2'b10, 6'b100100, 0, 3'b000, 0, 32'hF0F0, 32'h0FF0);
    vecs[3] = mkVec(1, 5'd5, 5'd6, 32'h1, 32'h2, 32'd0, 2'b10, 6'b100101, 0, 3'b001, 0, 32'h1, 32'h2);
    vecs[4] = mkVec(1, 5'd7, 5'd8, 32'h3, 32'h9, 32'd0, 2'b10, 6'b101010, 0, 3'b111, 0, 32'h3, 32'h9);
    vecs[5] = mkVec(1, 5'd9, 5'd10, 32'h11, 32'h22, 32'd0, 2'b10, 6'b000000, 0, 3'b010, 1, 32'h11, 32'h22);
    vecs[6] = mkVec(1, 5'd1, 5'd2, 32'd100, 32'd55, 32'd16, 2'b00, 6'b111111, 1, 3'b010, 0, 32'd100, 32'd16);
    vecs[7] = mkVec(1, 5'd1, 5'd2, 32'd8, 32'd8, 32'd0, 2'b01, 6'b000000, 0, 3'b110, 0, 32'd8, 32'd8);
    vecs[8] = mkVec(1, 5'd1, 5'd2, 32'h100, 32'h7, 32'h00FF, 2'b11, 6'b000000, 1, 3'b001, 0, 32'h100, 32'h00FF);
    vecs[9] = mkVec(0, 5'd1, 5'd2, 32'hAB, 32'hCD, 32'd0, 2'b10, 6'b000000, 0, 3'b010, 0, 32'hAB, 32'hCD);

    // Reset held low while every input wanders randomly
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    clearFwd();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
                    $urandom, 2'($urandom), 6'($urandom), $urandom, $urandom, $urandom);
      stall = 1'($urandom);
      flush = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom); exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom); memwb_result = $urandom;
      tick();
      checkOutput("reset Signal", 32'(Signal), 32'd0);
      checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
      checkOutput("reset id_stall", 32'(id_stall), 32'd0);
    end
    stall = 1'b0;
    flush = 1'b0;
    clearFwd();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("reset dataA", dataA, 32'd0);
    checkOutput("reset ex_regwrite", 32'(ex_regwrite), 32'd0);
    tick();
    rst_n = 1'b1;

    // Decode and operand table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].rs, vecs[i].rt, 5'd20, vecs[i].rsData, vecs[i].rtData,
                    vecs[i].imm, vecs[i].aluop, vecs[i].funct, vecs[i].alusrc, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d Signal", i), 32'(Signal), 32'(vecs[i].expSig));
      checkOutput($sformatf("vec%0d ex_illegal", i), 32'(ex_illegal), 32'(vecs[i].expIll));
      checkOutput($sformatf("vec%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].valid));
      checkOutput($sformatf("vec%0d dataA", i), dataA, vecs[i].expA);
      checkOutput($sformatf("vec%0d dataB", i), dataB, vecs[i].expB);
    end

    // Forwarding priority on rs
    applyStimulus(1, 5'd3, 5'd8, 5'd10, 32'h1111, 32'h22, 32'd0, 2'b10, 6'b100000, 0, 0, 1);
    tick();
    id_valid = 1'b0;
    exmem_regwrite = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAAAA;
    memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBBBB;
    #1;
    checkOutput("fwd exmem wins", dataA, FWD ? 32'hAAAA : 32'h1111);
    exmem_regwrite = 1'b0;
    #1;
    checkOutput("fwd memwb", dataA, FWD ? 32'hBBBB : 32'h1111);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    checkOutput("fwd r0 ignored", dataA, 32'h1111);
    clearFwd();

    // alusrc selects the immediate while the store data still forwards
    applyStimulus(1, 5'd2, 5'd9, 5'd11, 32'h1, 32'h5, 32'hFFFFFFFC, 2'b00, 6'd0, 1, 0, 0);
    tick();
    id_valid = 1'b0;
    memwb_regwrite = 1'b1; memwb_rd = 5'd9; memwb_result = 32'd9;
    #1;
    checkOutput("alusrc dataB", dataB, 32'hFFFFFFFC);
    checkOutput("alusrc store", ex_store_data, FWD ? 32'd9 : 32'd5);
    clearFwd();

    // Load-use: lw r4 in EX, dependent in ID; stall holds, then one bubble
    applyStimulus(1, 5'd1, 5'd0, 5'd4, 32'd100, 32'd0, 32'd8, 2'b00, 6'd0, 1, 1, 1);
    tick();
    applyStimulus(1, 5'd2, 5'd4, 5'd5, 32'd1, 32'd2, 32'd0, 2'b10, 6'b100000, 0, 0, 1);
    #1;
    checkOutput("loaduse id_stall", 32'(id_stall), 32'd1);
    stall = 1'b1;
    tick();
    checkOutput("loaduse hold memread", 32'(ex_memread), 32'd1);
    checkOutput("loaduse hold id_stall", 32'(id_stall), 32'd1);
    stall = 1'b0;
    tick();
    checkOutput("bubble ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("bubble Signal", 32'(Signal), 32'd0);
    checkOutput("bubble ex_regwrite", 32'(ex_regwrite), 32'd0);
    checkOutput("bubble id_stall drop", 32'(id_stall), 32'd0);
    tick();
    checkOutput("dependent ex_valid", 32'(ex_valid), 32'd1);
    checkOutput("dependent ex_rd", 32'(ex_rd), 32'd5);

    // Stall holds the EX register for three cycles, then flush beats stall
    applyStimulus(1, 5'd6, 5'd7, 5'd8, 32'd100, 32'd40, 32'd0, 2'b10, 6'b100010, 0, 0, 1);
    tick();
    stall = 1'b1;
    applyStimulus(1, 5'd9, 5'd10, 5'd12, 32'd1, 32'd1, 32'd0, 2'b10, 6'b100101, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall%0d Signal", i), 32'(Signal), 32'b110);
      checkOutput($sformatf("stall%0d dataA", i), dataA, 32'd100);
      checkOutput($sformatf("stall%0d ex_rd", i), 32'(ex_rd), 32'd8);
    end
    flush = 1'b1;
    tick();
    checkOutput("flush ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("flush Signal", 32'(Signal), 32'd0);

    // Asynchronous reset during a stall drops the held instruction
    flush = 1'b0;
    stall = 1'b0;
    tick();
    checkOutput("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midstall reset ex_valid", 32'(ex_valid), 32'd0);
    checkOutput("midstall reset ex_rd", 32'(ex_rd), 32'd0);
    rst_n = 1'b1;
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
